dm_sram_responder: RTL and testbench

Word-addressed data-memory responder on the far side of the CPU's MEM-stage SRAM port. It accepts chip select, output enable, active-low per-byte write enables, a word address and write data, and returns registered read data one cycle later for WB-stage load sign-extension. After reset it runs a hardware clear sequence that zeroes the whole array, raising `DM_busy` so the core can stall. It sits in the top level between the CPU's `sram_DM_*` signals and nothing else.

---
 rtl/dm_sram_responder.sv | 106 ++++++++++
 tb/tb_dm_sram_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dm_sram_responder.sv
// Word-addressed data-memory responder for the MEM-stage SRAM port.
// Zeroes the array after reset while DM_busy stalls the core.
module dm_sram_responder #(
    parameter int ADDR_W   = 14,
    parameter int DEPTH    = 16384,
    parameter int CLEAR_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CS,
    input  logic              OE,
    input  logic [3:0]        WEB,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       DI,
    output logic [31:0]       DO,
    output logic              DM_busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam state_t RST_STATE = (CLEAR_EN != 0) ? CLEAR : READY;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   clr_addr;
    logic [ADDR_W:0]   clr_nxt;
    logic [31:0]       mem [DEPTH];

    logic              in_range;
    logic              rd_en;
    logic              wr_en;
    logic              clr_we;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  clr_idx;

    assign in_range = ({1'b0, A} < DEPTH_C);
    assign idx      = A[IDX_W-1:0];
    assign clr_idx  = clr_addr[IDX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RST_STATE;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_nxt;
        end
    end

    // Memory strobes are masked by rst so an edge that lands inside
    // reset never commits a port write.
    always_comb begin
        state_nxt = state;
        clr_nxt   = clr_addr;
        DM_busy   = 1'b0;
        clr_we    = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        unique case (state)
            CLEAR: begin
                DM_busy = 1'b1;
                clr_we  = ~rst;
                clr_nxt = clr_addr + 1'b1;
                if (clr_addr == CLR_LAST) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                rd_en = CS & OE;
                wr_en = ~rst & CS & (WEB != 4'hF) & in_range;
            end
            default: begin
                state_nxt = RST_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (!WEB[i]) begin
                    mem[idx][8*i +: 8] <= DI[8*i +: 8];
                end
            end
        end
    end

    // Read-first: the array value sampled here predates any same-edge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DO <= '0;
        end else if (rd_en) begin
            DO <= in_range ? mem[idx] : '0;
        end
    end

endmodule

// File: tb/tb_dm_sram_responder.sv
// Scoreboard bench for dm_sram_responder (16 words, 5-bit address).
// Read expectations are queued at issue time and compared one edge later.
module tb_dm_sram_responder;

    localparam int AW = 5;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          CS = 1'b0;
    logic          OE = 1'b0;
    logic [3:0]    WEB = 4'hF;
    logic [AW-1:0] A = '0;
    logic [31:0]   DI = '0;
    logic [31:0]   DO;
    logic          DM_busy;

    logic [31:0]   model [DP];
    logic [31:0]   exp_q [$];
    logic [31:0]   exp_do;
    int            n_cmp = 0;
    int            n_err = 0;

    dm_sram_responder #(
        .ADDR_W   (AW),
        .DEPTH    (DP),
        .CLEAR_EN (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .CS      (CS),
        .OE      (OE),
        .WEB     (WEB),
        .A       (A),
        .DI      (DI),
        .DO      (DO),
        .DM_busy (DM_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic op(input string tag, input logic cs, input logic oe,
                      input logic [3:0] web, input logic [AW-1:0] a,
                      input logic [31:0] di);
        logic rd;
        CS = cs;
        OE = oe;
        WEB = web;
        A = a;
        DI = di;
        rd = cs & oe;
        if (rd) begin
            exp_q.push_back((int'(a) < DP) ? model[a] : 32'h0);
        end
        if (cs && web != 4'hF && int'(a) < DP) begin
            for (int i = 0; i < 4; i++) begin
                if (!web[i]) model[a][8*i +: 8] = di[8*i +: 8];
            end
        end
        @(posedge clk);
        #1;
        if (rd) begin
            if (exp_q.size() == 0) begin
                check({tag, "_qempty"}, 32'h1, 32'h0);
            end else begin
                exp_do = exp_q.pop_front();
                check(tag, DO, exp_do);
            end
        end else begin
            check({tag, "_hold"}, DO, exp_do);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        CS = 1'b0;
        OE = 1'b0;
        WEB = 4'hF;
    endtask

    task automatic count_clear(input string tag, input bit poke);
        int cnt;
        cnt = 0;
        while (DM_busy && cnt < 40) begin
            if (poke && cnt == 3) begin
                CS = 1'b1;
                OE = 1'b1;
                WEB = 4'h0;
                A = 5'd2;
                DI = 32'hDEADBEEF;
            end else begin
                idle();
            end
            cnt++;
            @(negedge clk);
        end
        idle();
        check({tag, "_cycles"}, 32'(cnt), 32'd16);
        check({tag, "_do"}, DO, 32'h0);
        for (int i = 0; i < DP; i++) model[i] = 32'h0;
        exp_do = 32'h0;
    endtask

    initial begin
        exp_do = 32'h0;
        for (int i = 0; i < DP; i++) begin
            dut.mem[i] = $urandom;
            model[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        check("rst_do", DO, 32'h0);
        check("rst_busy", 32'(DM_busy), 32'd1);

        rst = 1'b0;
        count_clear("clear1", 1'b1);
        for (int i = 0; i < DP; i++) begin
            op("clr_rd", 1'b1, 1'b1, 4'hF, AW'(i), 32'h0);
        end

        op("bw_full", 1'b1, 1'b0, 4'b0000, 5'd5, 32'hAABBCCDD);
        op("bw_part", 1'b1, 1'b0, 4'b1101, 5'd5, 32'h0000EE00);
        op("bw_rd", 1'b1, 1'b1, 4'hF, 5'd5, 32'h0);
        check("bw_const", DO, 32'hAABBEEDD);

        op("rf_init", 1'b1, 1'b0, 4'b0000, 5'd3, 32'h11111111);
        op("rf_rw", 1'b1, 1'b1, 4'b0000, 5'd3, 32'h22222222);
        check("rf_old", DO, 32'h11111111);
        op("rf_rd", 1'b1, 1'b1, 4'hF, 5'd3, 32'h0);
        check("rf_new", DO, 32'h22222222);

        op("ho_init", 1'b1, 1'b0, 4'b0000, 5'd7, 32'h12345678);
        op("ho_rd", 1'b1, 1'b1, 4'hF, 5'd7, 32'h0);
        for (int i = 0; i < 3; i++) begin
            model[7] = 32'h12345678;
            CS = 1'b0;
            OE = 1'b1;
            WEB = 4'h0;
            A = 5'd7;
            DI = 32'hFFFFFFFF;
            @(posedge clk);
            #1;
            check("ho_do", DO, 32'h12345678);
            @(negedge clk);
        end
        op("ho_rd2", 1'b1, 1'b1, 4'hF, 5'd7, 32'h0);

        op("oor_wr", 1'b1, 1'b0, 4'b0000, 5'd20, 32'h55555555);
        op("oor_rd", 1'b1, 1'b1, 4'hF, 5'd20, 32'h0);
        op("oor_alias", 1'b1, 1'b1, 4'hF, 5'd4, 32'h0);

        for (int n = 0; n < 150; n++) begin
            op("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
               4'($urandom), AW'($urandom_range(0, 23)), $urandom);
        end

        op("pre_wr", 1'b1, 1'b0, 4'b0000, 5'd1, 32'hCAFEF00D);
        op("pre_rd", 1'b1, 1'b1, 4'hF, 5'd1, 32'h0);
        idle();
        rst = 1'b1;
        #1;
        check("rst2_do", DO, 32'h0);
        check("rst2_busy", 32'(DM_busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_do", DO, 32'h0);
        check("mid_busy", 32'(DM_busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        count_clear("clear2", 1'b0);
        for (int i = 0; i < DP; i++) begin
            op("clr2_rd", 1'b1, 1'b1, 4'hF, AW'(i), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
